// File: rtl/regfile_pkg.sv
// Shared constants and types for the 32x32 register file with one-hot write decode.
package regfile_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned NREGS  = 32;

  // Hard-wired zero register index
  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  // Debug dump sequencer states
  typedef enum logic [1:0] {
    StIdle,
    StDump,
    StDone
  } dump_state_e;

endpackage

// File: rtl/wdec5.sv
// One-hot write-address decoder with enable; inverse of the 5-bit destination-select mux.
// Bit 0 is never asserted so the zero register can not be written.
module wdec5 #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NREGS  = 32
) (
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output logic [NREGS-1:0]  strobe
);

  // Decode addr to a single strobe bit, gated by en, bit 0 forced low
  always_comb begin
    strobe = '0;
    if (en) begin
      strobe[addr] = 1'b1;
    end
    strobe[0] = 1'b0;
  end

endmodule

// File: rtl/reg_file_wdec.sv
// 32x32 register file: one write port (one-hot decoded), two combinational read ports and a
// valid/ready debug dump port that streams every register in index order.
// Optional build macro REGFILE_BYPASS_EN: forwards same-cycle write data to the read ports and
// to dump_data; when undefined a same-cycle read returns the old stored value.
module reg_file_wdec #(
  parameter int unsigned DATA_W = regfile_pkg::DATA_W,
  parameter int unsigned ADDR_W = regfile_pkg::ADDR_W,
  parameter int unsigned NREGS  = regfile_pkg::NREGS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              dump_req,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_idx,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_done
);

  import regfile_pkg::*;

  localparam logic [ADDR_W-1:0] ZeroIdx = ADDR_W'(ZERO_REG);
  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NREGS - 1);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [NREGS-1:0]  wstrb;
  dump_state_e       state_q;

  wdec5 #(
    .ADDR_W (ADDR_W),
    .NREGS  (NREGS)
  ) u_wdec5 (
    .en     (we),
    .addr   (waddr),
    .strobe (wstrb)
  );

  // Register storage: reset clears everything and wins over a same-cycle write
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NREGS); i++) begin
        if (wstrb[i]) begin
          regs_q[i] <= wdata;
        end
      end
    end
  end

  // Combinational read ports, index 0 always reads zero
  always_comb begin
    rdata1 = (raddr1 == ZeroIdx) ? '0 : regs_q[raddr1];
    rdata2 = (raddr2 == ZeroIdx) ? '0 : regs_q[raddr2];
`ifdef REGFILE_BYPASS_EN
    if (we && (waddr == raddr1) && (raddr1 != ZeroIdx)) begin
      rdata1 = wdata;
    end
    if (we && (waddr == raddr2) && (raddr2 != ZeroIdx)) begin
      rdata2 = wdata;
    end
`endif
  end

  // Dump data follows the stored register live, so a later write shows up while stalled
  always_comb begin
    dump_data = (dump_idx == ZeroIdx) ? '0 : regs_q[dump_idx];
`ifdef REGFILE_BYPASS_EN
    if (dump_valid && we && (waddr == dump_idx) && (dump_idx != ZeroIdx)) begin
      dump_data = wdata;
    end
`endif
  end

  // Dump sequencer with registered valid/index/done outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      dump_valid <= 1'b0;
      dump_idx   <= '0;
      dump_done  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          dump_done <= 1'b0;
          if (dump_req) begin
            state_q    <= StDump;
            dump_valid <= 1'b1;
            dump_idx   <= '0;
          end
        end
        StDump: begin
          if (dump_valid && dump_ready) begin
            if (dump_idx == LastIdx) begin
              state_q    <= StDone;
              dump_valid <= 1'b0;
              dump_idx   <= '0;
              dump_done  <= 1'b1;
            end else begin
              dump_idx <= dump_idx + ADDR_W'(1);
            end
          end
        end
        StDone: begin
          state_q   <= StIdle;
          dump_done <= 1'b0;
          dump_idx  <= '0;
        end
        default: begin
          state_q    <= StIdle;
          dump_valid <= 1'b0;
          dump_idx   <= '0;
          dump_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_wdec.sv
// Self-checking bench for reg_file_wdec: directed scenarios plus randomized traffic compared
// against an array-based model of the register contents and the dump word sequence.
module tb_reg_file_wdec;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic        dump_req;
  logic        dump_valid;
  logic        dump_ready;
  logic [4:0]  dump_idx;
  logic [31:0] dump_data;
  logic        dump_done;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model
  logic [31:0] mdl [32];
  bit          m_active;
  bit          m_done;
  int          m_idx;
  int          acc_q [$];
  bit          saw_done;

  reg_file_wdec dut (
    .clk        (clk),
    .reset      (reset),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .raddr1     (raddr1),
    .raddr2     (raddr2),
    .rdata1     (rdata1),
    .rdata2     (rdata2),
    .dump_req   (dump_req),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_idx   (dump_idx),
    .dump_data  (dump_data),
    .dump_done  (dump_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (we && waddr == a) return wdata;
`endif
    return mdl[a];
  endfunction

  function automatic logic [31:0] exp_dump();
    if (m_idx == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (we && int'(waddr) == m_idx) return wdata;
`endif
    return mdl[m_idx];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    m_active = 1'b0;
    m_done   = 1'b0;
    m_idx    = 0;
    acc_q.delete();
  endtask

  // Check outputs at the falling edge, then advance the model across the rising edge
  task automatic cycle();
    logic [4:0] seen_idx;
    @(negedge clk);
    check("rdata1", rdata1, exp_rd(raddr1));
    check("rdata2", rdata2, exp_rd(raddr2));
    check("dump_valid", 32'(dump_valid), 32'(m_active));
    check("dump_done", 32'(dump_done), 32'(m_done));
    check("dump_idx", 32'(dump_idx), 32'(m_idx));
    if (m_active) check("dump_data", dump_data, exp_dump());
    if (dump_done) saw_done = 1'b1;
    if (m_done) begin
      check("dump_word_count", 32'(acc_q.size()), 32'd32);
      foreach (acc_q[k]) begin
        if (acc_q[k] != k) check("dump_word_order", 32'(acc_q[k]), 32'(k));
      end
      acc_q.delete();
    end
    seen_idx = dump_idx;
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      if (we && waddr != 5'd0) mdl[waddr] = wdata;
      if (m_active && dump_ready) begin
        acc_q.push_back(int'(seen_idx));
        if (m_idx == 31) begin
          m_active = 1'b0;
          m_idx    = 0;
          m_done   = 1'b1;
        end else begin
          m_idx++;
        end
      end else if (m_done) begin
        m_done = 1'b0;
      end else if (!m_active && dump_req) begin
        m_active = 1'b1;
        m_idx    = 0;
      end
    end
    #1;
  endtask

  task automatic wait_done(input string tag, input int budget);
    saw_done = 1'b0;
    for (int k = 0; k < budget && !saw_done; k++) cycle();
    check(tag, 32'(saw_done), 32'd1);
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
    dump_req = 1'b0; dump_ready = 1'b0;
    saw_done = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // All registers read zero after reset
    for (int a = 0; a < 32; a++) begin
      raddr1 = 5'(a);
      raddr2 = 5'(31 - a);
      cycle();
    end

    // Basic write then read; write to reg0 is discarded
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; cycle();
    we = 1'b1; waddr = 5'd0; wdata = 32'h1234; raddr1 = 5'd5; raddr2 = 5'd0; cycle();
    we = 1'b0;
    @(negedge clk);
    check("reg5_readback", rdata1, 32'hDEADBEEF);
    check("reg0_zero", rdata2, 32'h0);
    @(posedge clk); #1;

    // Same-cycle write and read of reg9
    we = 1'b1; waddr = 5'd9; wdata = 32'hA5A5A5A5; raddr2 = 5'd9; cycle();
    we = 1'b0; cycle();

    // Full dump with ready held high
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; waddr = 5'(i); wdata = 32'(i) * 32'h11; raddr1 = 5'(i); cycle();
    end
    we = 1'b0; dump_ready = 1'b1; dump_req = 1'b1; cycle();
    dump_req = 1'b0;
    wait_done("dump_full_done", 100);
    cycle(); cycle();

    // Dump with ready pattern 1,0,0 and a stray request mid-dump
    dump_req = 1'b1; dump_ready = 1'b1; cycle();
    dump_req = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 200 && !saw_done; k++) begin
      dump_ready = (k % 3 == 0);
      dump_req   = (k == 7);
      we         = ($urandom_range(0, 3) == 0);
      waddr      = 5'($urandom);
      wdata      = $urandom;
      cycle();
    end
    check("dump_stall_done", 32'(saw_done), 32'd1);
    we = 1'b0; dump_req = 1'b0; cycle(); cycle();

    // Reset in the middle of a dump
    dump_req = 1'b1; dump_ready = 1'b1; cycle();
    dump_req = 1'b0;
    for (int k = 0; k < 40 && m_idx != 12; k++) cycle();
    check("reached_idx12", 32'(dump_idx), 32'd12);
    reset = 1'b1; cycle();
    reset = 1'b0;
    saw_done = 1'b0;
    for (int a = 0; a < 32; a++) begin
      raddr1 = 5'(a);
      raddr2 = 5'(a);
      cycle();
    end
    check("no_done_after_reset", 32'(saw_done), 32'd0);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      reset      = ($urandom_range(0, 499) == 0);
      we         = $urandom_range(0, 1) == 1;
      waddr      = 5'($urandom);
      wdata      = $urandom;
      raddr1     = 5'($urandom);
      raddr2     = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
      dump_req   = ($urandom_range(0, 15) == 0);
      dump_ready = $urandom_range(0, 2) != 0;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_wdec.md
Name: reg_file_wdec

Overview:
- 32x32 general-purpose register file for the single-cycle CPU.
- Sits at the receiving end of the 5-bit destination-select path: it consumes the selected write address, decodes it one-hot and writes on the clock edge.
- Provides two combinational read ports for rs/rt.
- Provides a handshaked debug dump port that streams all registers out in sequence.

Parameters:
- DATA_W, 32, register and data width
- ADDR_W, 5, register address width
- NREGS, 32, register count; must equal 2**ADDR_W

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- we  in  1  write enable (RegWrite)
- waddr  in  ADDR_W  destination register, from the destination-select mux
- wdata  in  DATA_W  write-back data
- raddr1  in  ADDR_W  read port 1 address (rs)
- raddr2  in  ADDR_W  read port 2 address (rt)
- rdata1  out  DATA_W  read port 1 data
- rdata2  out  DATA_W  read port 2 data
- dump_req  in  1  one-cycle request to start a register dump
- dump_valid  out  1  dump word valid
- dump_ready  in  1  consumer accepts dump word
- dump_idx  out  ADDR_W  index of the current dump word
- dump_data  out  DATA_W  contents of register dump_idx
- dump_done  out  1  one-cycle pulse after the last word is accepted

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high on port reset.
- Reset effects: all registers go to 0, the dump FSM goes to IDLE, and dump_valid, dump_done and dump_idx all go to 0.
- Write: on the rising edge with we=1 and waddr!=0, reg[waddr] <= wdata.
  - waddr=0 writes are discarded; reg0 always reads 0.
  - The write strobe comes from a one-hot decode of waddr gated by we.
  - reset takes priority over a write in the same cycle.
- Read: rdata1/rdata2 are combinational, reg[raddr] with 0 latency; raddr=0 returns 0.
  - A read of a register being written in the same cycle returns the old value (no bypass; see the optional feature).
- Dump FSM states: IDLE, DUMP, DONE.
  - IDLE: dump_valid=0. dump_req=1 moves to DUMP with dump_idx=0.
  - DUMP: dump_valid=1; dump_data=reg[dump_idx], combinational and live.
    - If dump_valid && dump_ready: when dump_idx==NREGS-1, go to DONE; otherwise dump_idx increments.
    - Without ready, dump_idx and dump_valid hold.
  - DONE: dump_done=1 for exactly one cycle, dump_idx resets to 0, then return to IDLE.
  - dump_req is ignored outside IDLE.
- Simultaneous write and dump of the same index: dump_data shows the pre-write value in that cycle. If not accepted, it shows the new value next cycle.
- Reset during DUMP or DONE: the FSM goes to IDLE, dump_valid drops the next cycle, and no dump_done is generated.
- dump_idx wraps only through DONE and never overflows past NREGS-1.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined: write-through forwarding.
  - rdataN = wdata when we && waddr==raddrN && raddrN!=0.
  - dump_data forwards likewise when dump_valid.
- Undefined: reads return stored contents only (old value during same-cycle write).
- Write timing and reset are identical in both builds.

Decomposition:
- Package regfile_pkg:
  - DATA_W, ADDR_W, NREGS constants.
  - Dump FSM state enum (IDLE, DUMP, DONE).
  - ZERO_REG index constant = 0.
- Sub-module wdec5: ADDR_W-to-NREGS one-hot decoder with enable, producing the per-register write strobes.
  - Bit 0 is forced low.
  - It is the inverse of the 5-bit select mux.

Test Plan:
- Reset, then read all 32 addresses -> every rdata1/rdata2 = 0.
- we=1, waddr=5, wdata=0xDEADBEEF; next cycle raddr1=5 -> rdata1=0xDEADBEEF. Also we=1, waddr=0, wdata=0x1234 -> reg0 still reads 0.
- Same cycle: we=1, waddr=9, wdata=0xA5A5A5A5, raddr2=9 ->
  - without REGFILE_BYPASS_EN: old value 0;
  - with REGFILE_BYPASS_EN: 0xA5A5A5A5;
  - next cycle: 0xA5A5A5A5 in both builds.
- Load reg[i]=i*0x11 for i=1..31, pulse dump_req, hold dump_ready=1 -> 32 consecutive words, idx 0..31, data i*0x11 (idx0=0), dump_done one cycle after idx 31, then IDLE.
- Dump with dump_ready toggling 1,0,0,1,... -> no word skipped or repeated, idx/data held while ready=0; dump_req pulsed mid-dump is ignored.
- Assert reset with dump_idx=12 in DUMP -> next cycle dump_valid=0, dump_idx=0, no dump_done, all registers 0.
